// File: rtl/usb_app_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_app_pkg                                            |
// | Description : Shared types and constants for usb_cdc app-side blocks |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package usb_app_pkg;

  localparam int         C_BYTE_W   = 8;
  localparam logic [7:0] C_TAG_BASE = 8'hF0;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Width of an index into n requesters; never zero so N=1 still has a signal
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_pick                                                |
// | Description : Combinational round-robin picker. Searches from        |
// |               ptr_i+1 upward, wrapping, and returns the first        |
// |               active request as one-hot, index and found flag.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W-1:0] w_cand;

  // Walk candidates ptr+1 .. ptr+N_REQ (the pointer itself comes last)
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    w_cand   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = IDX_W'((int'(ptr_i) + i) % N_REQ);
      if (!found_o && req_i[w_cand]) begin
        found_o          = 1'b1;
        idx_o            = w_cand;
        onehot_o[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_tx_arbiter                                         |
// | Description : Burst-granular round-robin arbiter sharing the usb_cdc |
// |               IN byte stream between N_REQ sources, with optional    |
// |               per-burst source tag byte.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module usb_tx_arbiter
  import usb_app_pkg::*;
#(
  parameter int         N_REQ        = 2,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 16,
  parameter bit         TAG_EN       = 1'b1,
  parameter logic [7:0] TAG_BASE     = C_TAG_BASE
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [C_BYTE_W*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [C_BYTE_W-1:0]       in_data_o,
  output logic                      in_valid_o,
  input  logic                      in_ready_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o
);

  localparam int                IDX_W      = idx_width(N_REQ);
  localparam int                IDLE_W     = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] C_IDLE_SAT = (IDLE_TIMEOUT > 0) ? IDLE_W'(IDLE_TIMEOUT)
                                                                : {IDLE_W{1'b1}};
  localparam logic [IDLE_W:0]   C_TIMEOUT  = (IDLE_W + 1)'(IDLE_TIMEOUT);
  localparam logic [8:0]        C_MAX      = 9'(MAX_BURST);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_gnt_idx;
  logic [N_REQ-1:0]    r_grant;
  logic [7:0]          r_byte_cnt;
  logic [IDLE_W-1:0]   r_idle_cnt;

  logic [N_REQ-1:0]    w_pick_onehot;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_found;
  logic [C_BYTE_W-1:0] w_gnt_data;
  logic                w_gnt_valid;
  logic                w_gnt_last;
  logic                w_xfer;
  logic                w_hit_max;
  logic                w_timeout;
  logic                w_release;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req_valid_i),
    .ptr_i    (r_ptr),
    .onehot_o (w_pick_onehot),
    .idx_o    (w_pick_idx),
    .found_o  (w_pick_found)
  );

  // AND-OR mux of the granted requester's byte
  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_grant[k]) w_gnt_data = w_gnt_data | req_data_i[C_BYTE_W*k +: C_BYTE_W];
    end
  end

  assign w_gnt_valid = |(req_valid_i & r_grant);
  assign w_gnt_last  = |(req_last_i & r_grant);
  assign w_xfer      = (r_state == ST_DATA) && w_gnt_valid && in_ready_i;
  assign w_hit_max   = (({1'b0, r_byte_cnt} + 9'd1) == C_MAX);
  // Fires on the cycle whose idle count would reach the limit, so the
  // grant is gone on the following cycle
  assign w_timeout   = (IDLE_TIMEOUT != 0) && (r_state == ST_DATA) && !w_gnt_valid &&
                       (({1'b0, r_idle_cnt} + (IDLE_W + 1)'(1)) == C_TIMEOUT);
  assign w_release   = (w_xfer && (w_gnt_last || w_hit_max)) || w_timeout;

  assign grant_o = (r_state != ST_IDLE) ? r_grant : '0;
  assign busy_o  = (r_state != ST_IDLE);

  // Next-state and stream outputs; nothing is driven while arbitrating
  always_comb begin
    w_state_nxt = r_state;
    in_valid_o  = 1'b0;
    in_data_o   = '0;
    req_ready_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) w_state_nxt = TAG_EN ? ST_TAG : ST_DATA;
      end
      ST_TAG: begin
        in_valid_o = 1'b1;
        in_data_o  = TAG_BASE + 8'(r_gnt_idx);
        if (in_ready_i) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        in_valid_o  = w_gnt_valid;
        in_data_o   = w_gnt_data;
        req_ready_o = r_grant & {N_REQ{in_ready_i}};
        if (w_release) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, grant/pointer capture and burst counters
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_ptr      <= IDX_W'(N_REQ - 1);
      r_gnt_idx  <= '0;
      r_grant    <= '0;
      r_byte_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_gnt_idx  <= w_pick_idx;
            r_grant    <= w_pick_onehot;
            r_ptr      <= w_pick_idx;
            r_byte_cnt <= '0;
            r_idle_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_xfer) r_byte_cnt <= r_byte_cnt + 8'd1;
          if (w_gnt_valid)                  r_idle_cnt <= '0;
          else if (r_idle_cnt != C_IDLE_SAT) r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_usb_tx_arbiter                                      |
// | Description : Directed self-checking bench for usb_tx_arbiter        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_usb_tx_arbiter;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rstn_i;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [7:0]   in_data;
  logic         in_valid, in_ready;
  logic [N-1:0] grant;
  logic         busy;

  always #5 clk = ~clk;

  usb_tx_arbiter #(
    .N_REQ(N), .MAX_BURST(64), .IDLE_TIMEOUT(16), .TAG_EN(1'b1), .TAG_BASE(8'hF0)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .req_data_i(req_data), .req_valid_i(req_valid), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .in_data_o(in_data), .in_valid_o(in_valid), .in_ready_i(in_ready),
    .grant_o(grant), .busy_o(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Source model: per-requester byte list with last flags
  logic [7:0] mem [N][128];
  bit         lst [N][128];
  int         len [N];
  int         pos [N];
  bit         en  [N];
  bit         rdy_rand = 1'b0;

  logic [7:0] out_q [$];
  logic [7:0] exp_q [$];
  int         cyc;

  logic         s_valid, s_busy, p_pend;
  logic [7:0]   s_data, p_data;
  logic [N-1:0] s_grant, s_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int k, input int n, input logic [7:0] base, input int burst);
    for (int i = 0; i < n; i++) begin
      mem[k][i] = base + 8'(i);
      lst[k][i] = (burst != 0) && (((i + 1) % burst) == 0);
    end
    len[k] = n;
    pos[k] = 0;
    en[k]  = 1'b1;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      int p;
      p = (pos[k] < len[k]) ? pos[k] : 0;
      req_valid[k]     = en[k] && (pos[k] < len[k]);
      req_data[8*k +: 8] = (pos[k] < len[k]) ? mem[k][p] : 8'h00;
      req_last[k]      = (pos[k] < len[k]) ? lst[k][p] : 1'b0;
    end
    in_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock: drive at negedge, sample just after, commit transfers at posedge
  task automatic cycle();
    logic         xo;
    logic [N-1:0] rr;
    @(negedge clk);
    drive();
    #1;
    s_valid = in_valid; s_data = in_data; s_grant = grant;
    s_busy  = busy;     s_ready = req_ready;
    if (p_pend) begin
      chk("hold_valid", 32'(in_valid), 32'd1);
      chk("hold_data",  32'(in_data),  32'(p_data));
    end
    p_pend = in_valid && !in_ready;
    p_data = in_data;
    xo = in_valid && in_ready;
    rr = req_valid & req_ready;
    @(posedge clk);
    if (xo) out_q.push_back(s_data);
    for (int k = 0; k < N; k++) if (rr[k]) pos[k]++;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn_i = 1'b0;
    for (int k = 0; k < N; k++) begin en[k] = 1'b0; len[k] = 0; pos[k] = 0; end
    req_valid = '0; req_last = '0; req_data = '0;
    p_pend = 1'b0;
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
  endtask

  initial begin
    rstn_i = 1'b0; req_valid = '0; req_last = '0; req_data = '0; in_ready = 1'b1;
    p_pend = 1'b0;
    for (int k = 0; k < N; k++) begin en[k] = 1'b0; len[k] = 0; pos[k] = 0; end

    // Reset state
    #23;
    chk("rst_valid", 32'(in_valid), 32'd0);
    chk("rst_data",  32'(in_data),  32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant),    32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    @(negedge clk); rstn_i = 1'b1;

    // T1: single 3-byte burst from req0
    load(0, 3, 8'h01, 3);
    out_q.delete();
    cycle();
    chk("t1_idle_valid", 32'(s_valid), 32'd0);
    chk("t1_idle_grant", 32'(s_grant), 32'd0);
    chk("t1_idle_busy",  32'(s_busy),  32'd0);
    cycle();
    chk("t1_tag_valid", 32'(s_valid), 32'd1);
    chk("t1_tag_data",  32'(s_data),  32'hF0);
    chk("t1_tag_grant", 32'(s_grant), 32'd1);
    chk("t1_tag_busy",  32'(s_busy),  32'd1);
    chk("t1_tag_ready", 32'(s_ready), 32'd0);
    cycle();
    chk("t1_d0_data",  32'(s_data),  32'h01);
    chk("t1_d0_ready", 32'(s_ready), 32'd1);
    cycle();
    chk("t1_d1_data",  32'(s_data),  32'h02);
    cycle();
    chk("t1_d2_data",  32'(s_data),  32'h03);
    chk("t1_d2_grant", 32'(s_grant), 32'd1);
    cycle();
    chk("t1_end_grant", 32'(s_grant), 32'd0);
    chk("t1_end_busy",  32'(s_busy),  32'd0);
    chk("t1_end_valid", 32'(s_valid), 32'd0);
    chk("t1_count", 32'(out_q.size()), 32'd4);
    exp_q = '{8'hF0, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 4; i++)
      chk("t1_stream", 32'(out_q.size() > i ? out_q[i] : 8'hxx), 32'(exp_q[i]));

    // T2: both requesters, 2-byte bursts, alternating with one bubble each
    do_reset();
    load(0, 4, 8'hA1, 2);
    load(1, 4, 8'hB1, 2);
    out_q.delete(); cyc = 0;
    while (out_q.size() < 12 && cyc < 50) cycle();
    chk("t2_cycles", 32'(cyc), 32'd16);
    exp_q = '{8'hF0, 8'hA1, 8'hA2, 8'hF1, 8'hB1, 8'hB2,
              8'hF0, 8'hA3, 8'hA4, 8'hF1, 8'hB3, 8'hB4};
    for (int i = 0; i < 12; i++)
      chk("t2_stream", 32'(out_q.size() > i ? out_q[i] : 8'hxx), 32'(exp_q[i]));

    // T3: req1 streams 100 bytes without last; MAX_BURST splits it
    load(1, 100, 8'h00, 0);
    out_q.delete(); cyc = 0;
    while (out_q.size() < 102 && cyc < 200) cycle();
    chk("t3_cycles", 32'(cyc), 32'd104);
    chk("t3_count", 32'(out_q.size()), 32'd102);
    exp_q.delete();
    exp_q.push_back(8'hF1);
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hF1);
    for (int i = 64; i < 100; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 102; i++)
      chk("t3_stream", 32'(out_q.size() > i ? out_q[i] : 8'hxx), 32'(exp_q[i]));

    // Timeout: req1 stays granted but silent; released after 16 low cycles
    repeat (15) cycle();
    cycle();
    chk("t3_to16_busy",  32'(s_busy),  32'd1);
    chk("t3_to16_grant", 32'(s_grant), 32'd2);
    cycle();
    chk("t3_to17_busy",  32'(s_busy),  32'd0);
    chk("t3_to17_grant", 32'(s_grant), 32'd0);

    // T4: 15 idle cycles keep the grant; burst resumes without a new tag
    load(0, 4, 8'hC1, 4);
    out_q.delete();
    repeat (3) cycle();
    en[0] = 1'b0;
    repeat (15) cycle();
    chk("t4_hold_busy",  32'(s_busy),  32'd1);
    chk("t4_hold_grant", 32'(s_grant), 32'd1);
    en[0] = 1'b1;
    cycle();
    chk("t4_resume_valid", 32'(s_valid), 32'd1);
    chk("t4_resume_data",  32'(s_data),  32'hC2);
    cyc = 0;
    while (out_q.size() < 5 && cyc < 20) cycle();
    exp_q = '{8'hF0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    chk("t4_count", 32'(out_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("t4_stream", 32'(out_q.size() > i ? out_q[i] : 8'hxx), 32'(exp_q[i]));

    // T5: random in_ready; order and content preserved, outputs held
    load(1, 20, 8'h40, 10);
    load(0, 20, 8'h80, 20);
    rdy_rand = 1'b1;
    out_q.delete(); cyc = 0;
    while (out_q.size() < 43 && cyc < 400) cycle();
    rdy_rand = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'hF1);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'h40 + 8'(i));
    exp_q.push_back(8'hF0);
    for (int i = 0; i < 20; i++) exp_q.push_back(8'h80 + 8'(i));
    exp_q.push_back(8'hF1);
    for (int i = 10; i < 20; i++) exp_q.push_back(8'h40 + 8'(i));
    chk("t5_count", 32'(out_q.size()), 32'd43);
    for (int i = 0; i < 43; i++)
      chk("t5_stream", 32'(out_q.size() > i ? out_q[i] : 8'hxx), 32'(exp_q[i]));
    repeat (3) cycle();

    // T6: asynchronous reset mid-DATA, then req0 wins with a fresh tag
    load(0, 10, 8'hE0, 0);
    repeat (4) cycle();
    chk("t6_pre_busy", 32'(s_busy), 32'd1);
    @(negedge clk);
    drive();
    #1;
    rstn_i = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(in_valid),  32'd0);
    chk("t6_rst_data",  32'(in_data),   32'd0);
    chk("t6_rst_grant", 32'(grant),     32'd0);
    chk("t6_rst_busy",  32'(busy),      32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    p_pend = 1'b0;
    load(1, 4, 8'h55, 0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    cycle();
    chk("t6_idle_grant", 32'(s_grant), 32'd0);
    cycle();
    chk("t6_tag_data",  32'(s_data),  32'hF0);
    chk("t6_tag_grant", 32'(s_grant), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
